// File: rtl/even_divisor_monitor.sv
// Receiver-side checker for divided clocks: measures the high/low phase lengths of
// clk_div_in in clk cycles and reports the locked ratio, duty correctness and faults.
module even_divisor_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_div_in,
  output logic [CNT_W:0]   div_ratio,
  output logic             locked,
  output logic             duty_ok,
  output logic             period_err,
  output logic             stuck
);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    HALF   = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_M   = 4'(LOCK_CNT);
  localparam logic [3:0]       MATCH_1  = 4'd1;

  logic             sync1_q, sync2_q, sdly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_len_q, hi_len_d;
  logic [CNT_W-1:0] lo_len_q, lo_len_d;
  state_t           state_q, state_d;
  logic [CNT_W:0]   ref_q, ref_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W:0]   div_q, div_d;
  logic             locked_q, locked_d;
  logic             duty_q, duty_d;
  logic             err_q, err_d;
  logic             stuck_q, stuck_d;

  logic             rise_s, fall_s, edge_s, sat_s, duty_eq_s;
  logic [CNT_W:0]   period_s;
  logic [3:0]       match_inc_s;

  // Edge detection and phase-length measurement
  always_comb begin
    rise_s   = sync2_q & ~sdly_q;
    fall_s   = ~sync2_q & sdly_q;
    edge_s   = rise_s | fall_s;
    sat_s    = (cnt_q == CNT_MAX) && !edge_s;
    hi_len_d = hi_len_q;
    lo_len_d = lo_len_q;
    cnt_d    = cnt_q;
    if (edge_s) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    if (fall_s) begin
      hi_len_d = cnt_q;
    end else begin
      hi_len_d = hi_len_q;
    end
    // the rise being processed closes the low phase, so its length is cnt_q itself
    if (rise_s) begin
      lo_len_d = cnt_q;
    end else begin
      lo_len_d = lo_len_q;
    end
    period_s    = {1'b0, hi_len_q} + {1'b0, lo_len_d};
    duty_eq_s   = (hi_len_q == lo_len_d);
    match_inc_s = match_q + MATCH_1;
  end

  // Acquisition / lock state machine and status next-state
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    div_d    = div_q;
    locked_d = locked_q;
    duty_d   = duty_q;
    err_d    = 1'b0;
    stuck_d  = stuck_q;
    if (edge_s) begin
      stuck_d = 1'b0;
    end else begin
      stuck_d = stuck_q;
    end
    if (sat_s) begin
      stuck_d  = 1'b1;
      locked_d = 1'b0;
      duty_d   = 1'b0;
      match_d  = 4'd0;
      state_d  = ACQ;
    end else begin
      case (state_q)
        ACQ: begin
          if (rise_s) begin
            state_d = HALF;
          end else begin
            state_d = ACQ;
          end
        end
        HALF: begin
          if (rise_s) begin
            ref_d   = period_s;
            match_d = MATCH_1;
            state_d = TRACK;
          end else begin
            state_d = HALF;
          end
        end
        TRACK: begin
          if (rise_s && (period_s == ref_q)) begin
            if (match_inc_s >= LOCK_M) begin
              match_d  = LOCK_M;
              locked_d = 1'b1;
              div_d    = period_s;
              duty_d   = duty_eq_s;
              state_d  = LOCKED;
            end else begin
              match_d  = match_inc_s;
            end
          end else if (rise_s) begin
            ref_d   = period_s;
            match_d = MATCH_1;
          end else begin
            state_d = TRACK;
          end
        end
        LOCKED: begin
          // div_q is deliberately left alone so the last locked ratio stays readable
          if (rise_s && (period_s != div_q)) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            duty_d   = 1'b0;
            ref_d    = period_s;
            match_d  = MATCH_1;
            state_d  = TRACK;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d = ACQ;
        end
      endcase
    end
  end

  // All state, synchronizer and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sdly_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      hi_len_q <= {CNT_W{1'b0}};
      lo_len_q <= {CNT_W{1'b0}};
      state_q  <= ACQ;
      ref_q    <= {(CNT_W+1){1'b0}};
      match_q  <= 4'd0;
      div_q    <= {(CNT_W+1){1'b0}};
      locked_q <= 1'b0;
      duty_q   <= 1'b0;
      err_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      sync1_q  <= clk_div_in;
      sync2_q  <= sync1_q;
      sdly_q   <= sync2_q;
      cnt_q    <= cnt_d;
      hi_len_q <= hi_len_d;
      lo_len_q <= lo_len_d;
      state_q  <= state_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      div_q    <= div_d;
      locked_q <= locked_d;
      duty_q   <= duty_d;
      err_q    <= err_d;
      stuck_q  <= stuck_d;
    end
  end

  assign div_ratio  = div_q;
  assign locked     = locked_q;
  assign duty_ok    = duty_q;
  assign period_err = err_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_even_divisor_monitor.sv
// Randomized bench for even_divisor_monitor against a period-run reference model.
module tb_even_divisor_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clk_div_in;
  logic [8:0] div_ratio;
  logic       locked, duty_ok, period_err, stuck;

  even_divisor_monitor #(.CNT_W(8), .LOCK_CNT(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div_in (clk_div_in),
    .div_ratio  (div_ratio),
    .locked     (locked),
    .duty_ok    (duty_ok),
    .period_err (period_err),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int err_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (period_err === 1'b1) err_seen <= err_seen + 1;

  int nvec = 0;
  int nfail = 0;

  // Reference model: complete periods since acquisition and the run of equal ones
  typedef struct { int eff; logic lk; logic dt; logic st; logic [8:0] dv; } snap_t;
  snap_t pq[$];
  int   m_rises, m_hi, m_prev_len, m_run_val, m_run_len, m_div, m_err;
  logic m_locked, m_duty, m_stuck, cur;
  logic exp_lk, exp_dt, exp_st;
  logic [8:0] exp_dv;

  task automatic push_snap(input int eff);
    snap_t s;
    s.eff = eff; s.lk = m_locked; s.dt = m_duty; s.st = m_stuck; s.dv = 9'(m_div);
    pq.push_back(s);
  endtask

  task automatic apply_due();
    while (pq.size() > 0 && pq[0].eff <= cyc) begin
      exp_lk = pq[0].lk; exp_dt = pq[0].dt; exp_st = pq[0].st; exp_dv = pq[0].dv;
      void'(pq.pop_front());
    end
  endtask

  task automatic model_reset(input logic clear_div);
    m_rises = 0; m_hi = 0; m_prev_len = 0; m_run_val = 0; m_run_len = 0;
    m_locked = 1'b0; m_duty = 1'b0; m_stuck = 1'b0; cur = 1'b0;
    if (clear_div) m_div = 0;
    pq.delete();
    exp_lk = 1'b0; exp_dt = 1'b0; exp_st = 1'b0; exp_dv = 9'(m_div);
  endtask

  // Holds clk_div_in at lvl for len cycles; updates the model on the edge it creates
  task automatic drive_phase(input logic lvl, input int len);
    int period;
    if (lvl != cur) begin
      m_stuck = 1'b0;
      if (lvl) begin
        if (m_rises == 0) begin
          m_rises = 1;
        end else begin
          period = m_hi + m_prev_len;
          if (m_run_len > 0 && period == m_run_val) begin
            m_run_len++;
          end else begin
            if (m_run_len >= 4) m_err++;
            m_run_val = period; m_run_len = 1;
            m_locked = 1'b0; m_duty = 1'b0;
          end
          if (m_run_len == 4) begin
            m_locked = 1'b1; m_div = period; m_duty = (m_hi == m_prev_len);
          end
        end
      end else begin
        m_hi = m_prev_len;
      end
      push_snap(cyc + 3);
      m_prev_len = len;
    end else begin
      m_prev_len += len;
    end
    clk_div_in = lvl;
    cur = lvl;
    repeat (len) @(negedge clk);
    if (m_prev_len > 260) begin
      m_stuck = 1'b1; m_locked = 1'b0; m_duty = 1'b0; m_rises = 0; m_run_len = 0;
      push_snap(cyc);
    end
    apply_due();
  endtask

  task automatic drive_period(input int hi, input int lo);
    drive_phase(1'b1, hi);
    drive_phase(1'b0, lo);
  endtask

  task automatic test_reset();
    nvec++;
    if ({locked, duty_ok, stuck, period_err, div_ratio} !== 13'd0) begin
      nfail++;
      $display("FAIL reset_state: got lk=%b dt=%b st=%b pe=%b div=%0d, want all 0",
               locked, duty_ok, stuck, period_err, div_ratio);
    end
  endtask

  task automatic test_div2();
    int e0 = err_seen;
    for (int i = 0; i < 12; i++) begin
      drive_period(1, 1);
      nvec++;
      if ({locked, duty_ok, stuck, div_ratio} !== {exp_lk, exp_dt, exp_st, exp_dv}) begin
        nfail++;
        $display("FAIL div2 p%0d: got lk=%b dt=%b st=%b div=%0d, want lk=%b dt=%b st=%b div=%0d",
                 i, locked, duty_ok, stuck, div_ratio, exp_lk, exp_dt, exp_st, exp_dv);
      end
    end
    drive_phase(cur, 4); #1;
    nvec++;
    if ({locked, duty_ok, stuck, div_ratio, err_seen - e0} !== {1'b1, 1'b1, 1'b0, 9'd2, 0}) begin
      nfail++;
      $display("FAIL div2_final: got lk=%b dt=%b st=%b div=%0d errs=%0d, want 1 1 0 2 0",
               locked, duty_ok, stuck, div_ratio, err_seen - e0);
    end
  endtask

  task automatic test_div10();
    for (int i = 0; i < 8; i++) begin
      drive_period(5, 5);
      nvec++;
      if ({locked, duty_ok, stuck, div_ratio} !== {exp_lk, exp_dt, exp_st, exp_dv}) begin
        nfail++;
        $display("FAIL div10 p%0d: got lk=%b dt=%b st=%b div=%0d, want lk=%b dt=%b st=%b div=%0d",
                 i, locked, duty_ok, stuck, div_ratio, exp_lk, exp_dt, exp_st, exp_dv);
      end
    end
    nvec++;
    if ({locked, duty_ok, div_ratio} !== {1'b1, 1'b1, 9'd10}) begin
      nfail++;
      $display("FAIL div10_final: got lk=%b dt=%b div=%0d, want 1 1 10", locked, duty_ok, div_ratio);
    end
  endtask

  task automatic test_period_change();
    int e0;
    for (int i = 0; i < 8; i++) drive_period(2, 2);
    e0 = err_seen;
    for (int i = 0; i < 8; i++) begin
      drive_period(3, 3);
      nvec++;
      if ({locked, duty_ok, stuck, div_ratio} !== {exp_lk, exp_dt, exp_st, exp_dv}) begin
        nfail++;
        $display("FAIL change p%0d: got lk=%b dt=%b st=%b div=%0d, want lk=%b dt=%b st=%b div=%0d",
                 i, locked, duty_ok, stuck, div_ratio, exp_lk, exp_dt, exp_st, exp_dv);
      end
      if (i == 1) begin
        nvec++;
        if ({locked, div_ratio} !== {1'b0, 9'd4}) begin
          nfail++;
          $display("FAIL change_hold: got lk=%b div=%0d, want 0 4", locked, div_ratio);
        end
      end
    end
    nvec++;
    if ({locked, div_ratio, err_seen - e0} !== {1'b1, 9'd6, 1}) begin
      nfail++;
      $display("FAIL change_relock: got lk=%b div=%0d errs=%0d, want 1 6 1",
               locked, div_ratio, err_seen - e0);
    end
  endtask

  task automatic test_odd_duty();
    for (int i = 0; i < 7; i++) drive_period(3, 2);
    nvec++;
    if ({locked, duty_ok, stuck, div_ratio} !== {exp_lk, exp_dt, exp_st, exp_dv}
        || {locked, duty_ok, div_ratio} !== {1'b1, 1'b0, 9'd5}) begin
      nfail++;
      $display("FAIL odd_duty: got lk=%b dt=%b st=%b div=%0d, want lk=1 dt=0 st=0 div=5",
               locked, duty_ok, stuck, div_ratio);
    end
  endtask

  task automatic test_stuck();
    for (int i = 0; i < 6; i++) drive_period(1, 1);
    drive_phase(1'b1, 300);
    nvec++;
    if ({locked, duty_ok, stuck} !== {exp_lk, exp_dt, exp_st} || {stuck, locked} !== 2'b10) begin
      nfail++;
      $display("FAIL stuck_set: got st=%b lk=%b dt=%b, want st=1 lk=0 dt=0", stuck, locked, duty_ok);
    end
    drive_phase(1'b0, 4);
    nvec++;
    if (stuck !== 1'b0 || stuck !== exp_st) begin
      nfail++;
      $display("FAIL stuck_clear: got st=%b, want 0", stuck);
    end
    for (int i = 0; i < 8; i++) drive_period(1, 1);
    nvec++;
    if ({locked, duty_ok, stuck, div_ratio} !== {exp_lk, exp_dt, exp_st, exp_dv}
        || {locked, div_ratio} !== {1'b1, 9'd2}) begin
      nfail++;
      $display("FAIL stuck_relock: got lk=%b dt=%b st=%b div=%0d, want lk=1 div=2",
               locked, duty_ok, stuck, div_ratio);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    for (int i = 0; i < 8; i++) drive_period(5, 5);
    drive_phase(1'b1, 2);
    #2;
    rstn = 1'b0;
    clk_div_in = 1'b0;
    #1;
    nvec++;
    if ({locked, duty_ok, stuck, period_err, div_ratio} !== 13'd0) begin
      nfail++;
      $display("FAIL async_reset: got lk=%b dt=%b st=%b pe=%b div=%0d, want all 0",
               locked, duty_ok, stuck, period_err, div_ratio);
    end
    model_reset(1'b1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    e0 = err_seen;
    drive_phase(1'b0, 3);
    for (int i = 0; i < 8; i++) begin
      drive_period(5, 5);
      nvec++;
      if ({locked, duty_ok, stuck, div_ratio} !== {exp_lk, exp_dt, exp_st, exp_dv}) begin
        nfail++;
        $display("FAIL reacq p%0d: got lk=%b dt=%b st=%b div=%0d, want lk=%b dt=%b st=%b div=%0d",
                 i, locked, duty_ok, stuck, div_ratio, exp_lk, exp_dt, exp_st, exp_dv);
      end
    end
    drive_phase(cur, 4); #1;
    nvec++;
    if (err_seen - e0 !== 0) begin
      nfail++;
      $display("FAIL reacq_err: got %0d period_err pulses, want 0", err_seen - e0);
    end
  endtask

  task automatic test_random();
    int hi, lo, reps;
    for (int s = 0; s < 30; s++) begin
      hi = $urandom_range(1, 6);
      lo = $urandom_range(1, 6);
      reps = $urandom_range(1, 7);
      for (int r = 0; r < reps; r++) begin
        drive_period(hi, lo);
        nvec++;
        if ({locked, duty_ok, stuck, div_ratio} !== {exp_lk, exp_dt, exp_st, exp_dv}) begin
          nfail++;
          $display("FAIL random s%0d %0d/%0d: got lk=%b dt=%b st=%b div=%0d, want lk=%b dt=%b st=%b div=%0d",
                   s, hi, lo, locked, duty_ok, stuck, div_ratio, exp_lk, exp_dt, exp_st, exp_dv);
        end
      end
    end
  endtask

  task automatic test_err_count();
    drive_phase(cur, 6); #1;
    nvec++;
    if (err_seen !== m_err) begin
      nfail++;
      $display("FAIL err_total: got %0d period_err pulses, want %0d", err_seen, m_err);
    end
  endtask

  initial begin
    m_err = 0;
    m_div = 0;
    model_reset(1'b1);
    rstn = 1'b0;
    clk_div_in = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    drive_phase(1'b0, 3);
    test_div2();
    test_div10();
    test_period_change();
    test_odd_duty();
    test_stuck();
    test_err_count();
    test_reset_mid();
    test_random();
    test_err_count();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/even_divisor_monitor.md
Name: even_divisor_monitor

Overview:
- Receiver-side checker for divided clocks produced by the even divider.
- Samples one divided clock in the source `clk` domain and measures the high-phase and low-phase lengths in `clk` cycles.
- Reports the measured divide ratio, lock status and duty-cycle correctness.
- Flags period changes and a stuck input.
- Used in bring-up and BIST to confirm the clk_div2, clk_div4 and clk_div10 outputs.

Parameters:
- CNT_W, 8, width of the phase-length counters. Maximum measurable phase is 2^CNT_W-1 cycles.
- LOCK_CNT, 4, number of consecutive identical periods required to assert lock (legal range 2..15).

Ports:
- clk  input  1  reference clock; the divider's source clock.
- rstn  input  1  asynchronous active-low reset.
- clk_div_in  input  1  divided clock under test (clk-derived; synchronized internally).
- div_ratio  output  CNT_W+1  locked period in clk cycles (hi_len+lo_len).
- locked  output  1  stable period confirmed.
- duty_ok  output  1  locked and hi_len==lo_len.
- period_err  output  1  one-cycle pulse when a locked period changes.
- stuck  output  1  input has had no edge for 2^CNT_W-1 cycles.

Behaviour:
- Reset is asynchronous and active-low: reset is applied when rstn falls, independent of clk.
- Reset values:
  - all outputs 0;
  - counters 0;
  - synchronizer flops 0;
  - FSM in ACQ.
- Synchronizer and edge detection:
  - s = clk_div_in through a 2-flop synchronizer; s_d = s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- Phase counter cnt:
  - On rise or fall: latch the finished phase length (fall latches hi_len = cnt; rise latches lo_len = cnt), then set cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 2^CNT_W-1.
  - Example: a toggle-every-cycle input gives hi_len = lo_len = 1.
- Period: at each rise in state TRACK, period = hi_len + lo_len, computed CNT_W+1 bits wide with no overflow.
- FSM states:
  - ACQ: wait for the first rise; the preceding partial phase is discarded. rise -> HALF.
  - HALF: wait for fall (hi_len valid), then the next rise (lo_len valid). That rise computes the first period: ref <= period, match <= 1 -> TRACK.
  - TRACK, at each rise:
    - period==ref: match <= match+1 (saturating at LOCK_CNT). When match+1 reaches LOCK_CNT: locked <= 1, div_ratio <= period, duty_ok <= (hi_len==lo_len), -> LOCKED.
    - period!=ref: ref <= period, match <= 1.
  - LOCKED, at each rise:
    - period==div_ratio: no change.
    - period!=div_ratio: period_err pulses 1 cycle; locked <= 0; duty_ok <= 0; ref <= period; match <= 1; -> TRACK. div_ratio holds its last locked value until relock.
- Stuck:
  - When cnt reaches saturation in any state: stuck <= 1, locked <= 0, duty_ok <= 0, match <= 0, -> ACQ. period_err is not pulsed.
  - stuck clears on the next edge, rise or fall.
- Output timing: locked, duty_ok and div_ratio are registered and update the cycle after the qualifying rise is detected. Latency from the clk_div_in edge to rise detection is 3 cycles.
- Duty handling: odd periods or non-50% duty still lock; duty_ok=0 in that case.
- rstn assertion mid-measurement returns to ACQ immediately. The first post-reset partial phase is never used.

Test Plan:
- clk_div_in = clk_div2 pattern (toggle every clk) -> locked=1, div_ratio=2, duty_ok=1, no period_err, no stuck.
- clk_div_in = 5-high/5-low pattern (div10) -> locked within 5 input periods + 4 clk of the first rise; div_ratio=10; duty_ok=1.
- Input is locked at div4, then switched to 3-high/3-low -> exactly one period_err pulse, locked drops, then relocks with div_ratio=6 after LOCK_CNT periods; div_ratio reads 4 between the drop and the relock.
- 3-high/2-low input -> locked=1, div_ratio=5, duty_ok=0.
- Locked input held at 1 for 255 cycles (CNT_W=8) -> stuck=1, locked=0. Resuming div2 clears stuck on the first edge and relocks to 2.
- rstn pulsed low while locked on div10 -> all outputs 0 asynchronously; after release, reacquire with no spurious period_err.
